alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Registered, handshaked ALU control unit for the multi-cycle datapath.
- Decodes ALUOp plus the R-type funct field into the 4-bit ALU control word.
- Adds a sequencer for iterative mult/div: it stalls the issue side for a parametrised number of step cycles.
- Sits between the main control/decode stage and the ALU/MD unit.

Parameters:
- FUNCT_W, 6, width of the funct field.
- CTRL_W, 4, width of the ALU control word.
- MD_CYCLES, 32, md_step pulses per mult/div operation (legal range 1..255).
- CNT_W, 8, width of the iteration counter; must hold MD_CYCLES.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the in-flight op.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  unit accepts the op this cycle.
- alu_op  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type decode funct, 11 or (ori).
- funct  in  FUNCT_W  instruction funct field.
- out_valid  out  1  alu_ctrl/md_op valid to the ALU.
- out_ready  in  1  ALU consumes the output.
- alu_ctrl  out  CTRL_W  registered ALU control word.
- md_busy  out  1  mult/div sequence in progress.
- md_step  out  1  one-cycle strobe per MD iteration.
- md_last  out  1  coincides with the final md_step.
- md_op  out  2  00 mult, 01 multu, 10 div, 11 divu; valid while md_busy or on out_valid of an MD op.
- illegal  out  1  sticky illegal-funct flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; alu_ctrl=1000; out_valid=0; md_busy=0; md_step=0; md_last=0; md_op=00; illegal=0; counter=0.
- Decode, applied when alu_op=10:
  - add 100000->1000; and 100100->1100; addu 100001->0110; or 100101->0100.
  - sltu 101011->1111; sra 000011->0010; sll 000000->1011; srl 000010->1010; sub 100010->1001.
  - mult 011000 and multu 011001 -> 0001; div 011010 and divu 011011 -> 0011.
  - Any other funct -> 1000.
- Decode for other alu_op values: 00->1000, 01->1001, 11->0100.
- States: IDLE, HOLD, MD_RUN, MD_DONE.
- in_ready = (IDLE) or (HOLD and out_ready). Transfer occurs when in_valid and in_ready.
- IDLE/HOLD with transfer:
  - Non-MD op: register alu_ctrl, out_valid=1 next cycle, go to HOLD. Latency is 1 cycle.
  - MD op: register alu_ctrl and md_op, go to MD_RUN, counter=0, md_busy=1 next cycle.
- HOLD without transfer: if out_ready, out_valid drops to 0 and state goes to IDLE; otherwise hold all outputs stable.
- MD_RUN:
  - md_step=1 every cycle; counter increments.
  - md_last=1 when counter==MD_CYCLES-1, after which the state goes to MD_DONE.
  - in_ready=0 and out_valid=0 throughout.
  - MD_CYCLES=1 gives a single cycle with md_step and md_last both high.
- MD_DONE: out_valid=1, md_busy=0. Stay until out_ready, then go to IDLE (in_ready is not asserted in MD_DONE).
- flush=1 in any state: next cycle IDLE, out_valid=0, md_busy=0, md_step=0, counter=0. Any same-cycle in_valid is dropped. alu_ctrl keeps its last value. illegal is unaffected.
- Reset asserted mid-MD: outputs take reset values immediately, without waiting for clk.
- Output stability: alu_ctrl and md_op must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown funct with alu_op=10 decodes to alu_ctrl=0000 (nop) and is still handshaked as a non-MD op.
  - illegal sets on that transfer and stays set until reset; flush does not clear it.
- Undefined: an unknown funct decodes to 1000 (add); illegal is tied to 0.

Test Plan:
- After reset: in_valid=1, alu_op=10, funct=100010, out_ready=1 -> next cycle out_valid=1, alu_ctrl=1001. Back-to-back funct=100100 the following cycle -> alu_ctrl=1100 with no bubble.
- Backpressure: funct=101011 accepted, out_ready=0 for 3 cycles -> alu_ctrl=1111 stable, in_ready=0. Then out_ready=1 -> out_valid drops next cycle.
- MD_CYCLES=4, funct=011010 -> md_busy for 4 cycles with md_step=1111 and md_last on the 4th cycle, md_op=10. Then out_valid=1, alu_ctrl=0011.
- flush asserted on the 2nd md_step of a multu -> next cycle IDLE, md_busy=0, in_ready=1; a new alu_op=01 op yields alu_ctrl=1001.
- rst_n pulled low mid-MD_RUN, asynchronous to clk -> md_busy/out_valid are 0 immediately and alu_ctrl=1000.
- funct=111111 with alu_op=10: with the macro -> alu_ctrl=0000, illegal=1 and stays 1 through a subsequent flush. Without the macro -> alu_ctrl=1000, illegal=0.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU control unit with an iterative
// mult/div sequencer. It decodes alu_op/funct into the ALU control word. For
// mult/div ops it keeps the issue side stalled for MD_CYCLES md_step strobes.
//
// Optional feature macro: ALU_CTRL_ILLEGAL_TRAP_EN
//   defined   : an unknown R-type funct decodes to 0000 (nop). The op is
//               handshaked normally and sets the sticky 'illegal' flag.
//   undefined : an unknown funct decodes to 1000 (add). 'illegal' is tied low.
//
// state   | meaning
// IDLE    | no output pending, ready for a new op
// HOLD    | non-MD result presented (out_valid=1), waiting for out_ready
// MD_RUN  | mult/div iterating, one md_step per cycle, issue stalled
// MD_DONE | mult/div finished, result presented until out_ready
module alu_ctrl_seq #(
  parameter int FUNCT_W   = 6,
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               md_busy,
  output logic               md_step,
  output logic               md_last,
  output logic [1:0]         md_op,
  output logic               illegal
);

  typedef enum logic [1:0] {IDLE, HOLD, MD_RUN, MD_DONE} state_t;

  localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(4'b1001);
  localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] C_ADDU = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(4'b1111);
  localparam logic [CTRL_W-1:0] C_SRA  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(4'b1011);
  localparam logic [CTRL_W-1:0] C_SRL  = CTRL_W'(4'b1010);
  localparam logic [CTRL_W-1:0] C_MUL  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] C_DIV  = CTRL_W'(4'b0011);

  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_ADDU  = FUNCT_W'(6'b100001);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_SLTU  = FUNCT_W'(6'b101011);
  localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] F_SRL   = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] F_SRA   = FUNCT_W'(6'b000011);
  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'b011000);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'b011010);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);
  localparam logic             ONE_STEP = (MD_CYCLES == 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_md;
  logic              xfer;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic              dec_unk;
`endif

  // MD_DONE deliberately keeps in_ready low so the result is consumed first
  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign xfer     = in_valid && in_ready;

  // Combinational decode of alu_op/funct into control word and MD flag
  always_comb begin
    dec_ctrl = C_ADD;
    dec_md   = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    dec_unk  = 1'b0;
`endif
    case (alu_op)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_SUB;
      2'b11: dec_ctrl = C_OR;
      default: begin
        case (funct)
          F_ADD:   dec_ctrl = C_ADD;
          F_ADDU:  dec_ctrl = C_ADDU;
          F_SUB:   dec_ctrl = C_SUB;
          F_AND:   dec_ctrl = C_AND;
          F_OR:    dec_ctrl = C_OR;
          F_SLTU:  dec_ctrl = C_SLTU;
          F_SLL:   dec_ctrl = C_SLL;
          F_SRL:   dec_ctrl = C_SRL;
          F_SRA:   dec_ctrl = C_SRA;
          F_MULT, F_MULTU: begin
            dec_ctrl = C_MUL;
            dec_md   = 1'b1;
          end
          F_DIV, F_DIVU: begin
            dec_ctrl = C_DIV;
            dec_md   = 1'b1;
          end
          default: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            dec_ctrl = '0;
            dec_unk  = 1'b1;
`else
            dec_ctrl = C_ADD;
`endif
          end
        endcase
      end
    endcase
  end

`ifndef ALU_CTRL_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  // Control FSM with all outputs registered; flush outranks any transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_ctrl  <= C_ADD;
      out_valid <= 1'b0;
      md_busy   <= 1'b0;
      md_step   <= 1'b0;
      md_last   <= 1'b0;
      md_op     <= 2'b00;
      cnt       <= '0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      illegal   <= 1'b0;
`endif
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      md_busy   <= 1'b0;
      md_step   <= 1'b0;
      md_last   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (xfer) begin
            alu_ctrl <= dec_ctrl;
            if (dec_md) begin
              state     <= MD_RUN;
              md_op     <= funct[1:0];
              out_valid <= 1'b0;
              md_busy   <= 1'b1;
              md_step   <= 1'b1;
              md_last   <= ONE_STEP;
              cnt       <= '0;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
              if (dec_unk) illegal <= 1'b1;
`endif
            end
          end else if ((state == HOLD) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        MD_RUN: begin
          if (cnt == CNT_LAST) begin
            state     <= MD_DONE;
            md_busy   <= 1'b0;
            md_step   <= 1'b0;
            md_last   <= 1'b0;
            out_valid <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt     <= cnt + CNT_W'(1);
            md_last <= ((cnt + CNT_W'(1)) == CNT_LAST);
          end
        end
        MD_DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed-vector bench for alu_ctrl_seq, built with MD_CYCLES=4.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_ctrl;
  logic       md_busy;
  logic       md_step;
  logic       md_last;
  logic [1:0] md_op;
  logic       illegal;

  int vectors = 0;
  int errors  = 0;

  alu_ctrl_seq #(
    .FUNCT_W(6), .CTRL_W(4), .MD_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .md_busy(md_busy), .md_step(md_step),
    .md_last(md_last), .md_op(md_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_op = 2'b00;
    funct = 6'b0; out_ready = 1'b0;
    #12;
    chk("rst alu_ctrl", 8'(alu_ctrl), 8'h8);
    chk("rst out_valid", 8'(out_valid), 8'h0);
    chk("rst md_busy", 8'(md_busy), 8'h0);
    chk("rst md_step", 8'(md_step), 8'h0);
    chk("rst md_last", 8'(md_last), 8'h0);
    chk("rst md_op", 8'(md_op), 8'h0);
    chk("rst illegal", 8'(illegal), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", 8'(in_ready), 8'h1);
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [10]   = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
    logic [5:0] fns [10]   = '{6'b100000, 6'b100001, 6'b100101, 6'b000011, 6'b000000,
                               6'b000010, 6'b011000, 6'b011010, 6'b011011, 6'b101011};
    logic [3:0] exps [10]  = '{4'b1000, 4'b0110, 4'b0100, 4'b0010, 4'b1011,
                               4'b1010, 4'b1000, 4'b1001, 4'b0100, 4'b1111};
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b100010; out_ready = 1'b1;
    step();
    chk("sub out_valid", 8'(out_valid), 8'h1);
    chk("sub alu_ctrl", 8'(alu_ctrl), 8'h9);
    funct = 6'b100100;
    chk("b2b in_ready", 8'(in_ready), 8'h1);
    step();
    chk("and out_valid", 8'(out_valid), 8'h1);
    chk("and alu_ctrl", 8'(alu_ctrl), 8'hC);
    for (int i = 0; i < 10; i++) begin
      alu_op = ops[i]; funct = fns[i];
      step();
      chk($sformatf("dec%0d alu_ctrl", i), 8'(alu_ctrl), 8'(exps[i]));
      chk($sformatf("dec%0d out_valid", i), 8'(out_valid), 8'h1);
    end
    in_valid = 1'b0;
    step();
    chk("drain out_valid", 8'(out_valid), 8'h0);
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b101011; out_ready = 1'b0;
    step();
    funct = 6'b100000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d in_ready", i), 8'(in_ready), 8'h0);
      chk($sformatf("bp%0d out_valid", i), 8'(out_valid), 8'h1);
      chk($sformatf("bp%0d alu_ctrl", i), 8'(alu_ctrl), 8'hF);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 8'(in_ready), 8'h1);
    step();
    chk("bp drop out_valid", 8'(out_valid), 8'h0);
  endtask

  task automatic test_md_run();
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011010; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("md%0d busy", i), 8'(md_busy), 8'h1);
      chk($sformatf("md%0d step", i), 8'(md_step), 8'h1);
      chk($sformatf("md%0d last", i), 8'(md_last), (i == 3) ? 8'h1 : 8'h0);
      chk($sformatf("md%0d op", i), 8'(md_op), 8'h2);
      chk($sformatf("md%0d out_valid", i), 8'(out_valid), 8'h0);
      chk($sformatf("md%0d in_ready", i), 8'(in_ready), 8'h0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mddone%0d out_valid", i), 8'(out_valid), 8'h1);
      chk($sformatf("mddone%0d alu_ctrl", i), 8'(alu_ctrl), 8'h3);
      chk($sformatf("mddone%0d md_op", i), 8'(md_op), 8'h2);
      chk($sformatf("mddone%0d busy", i), 8'(md_busy), 8'h0);
      chk($sformatf("mddone%0d step", i), 8'(md_step), 8'h0);
      chk($sformatf("mddone%0d in_ready", i), 8'(in_ready), 8'h0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("mdexit out_valid", 8'(out_valid), 8'h0);
    chk("mdexit in_ready", 8'(in_ready), 8'h1);
  endtask

  task automatic test_flush();
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011001; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fl op", 8'(md_op), 8'h1);
    step();
    chk("fl 2nd step", 8'(md_step), 8'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl md_busy", 8'(md_busy), 8'h0);
    chk("fl md_step", 8'(md_step), 8'h0);
    chk("fl out_valid", 8'(out_valid), 8'h0);
    chk("fl in_ready", 8'(in_ready), 8'h1);
    chk("fl alu_ctrl kept", 8'(alu_ctrl), 8'h1);
    in_valid = 1'b1; alu_op = 2'b01;
    step();
    chk("fl new out_valid", 8'(out_valid), 8'h1);
    chk("fl new alu_ctrl", 8'(alu_ctrl), 8'h9);
    alu_op = 2'b11; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl drop out_valid", 8'(out_valid), 8'h0);
    chk("fl drop alu_ctrl", 8'(alu_ctrl), 8'h9);
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("ar pre busy", 8'(md_busy), 8'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar md_busy", 8'(md_busy), 8'h0);
    chk("ar out_valid", 8'(out_valid), 8'h0);
    chk("ar md_step", 8'(md_step), 8'h0);
    chk("ar alu_ctrl", 8'(alu_ctrl), 8'h8);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar in_ready", 8'(in_ready), 8'h1);
  endtask

  task automatic test_illegal();
    logic [7:0] exp_ctrl;
    logic [7:0] exp_ill;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    exp_ctrl = 8'h0; exp_ill = 8'h1;
`else
    exp_ctrl = 8'h8; exp_ill = 8'h0;
`endif
    chk("ill before", 8'(illegal), 8'h0);
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b111111; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ill out_valid", 8'(out_valid), 8'h1);
    chk("ill alu_ctrl", 8'(alu_ctrl), exp_ctrl);
    chk("ill flag", 8'(illegal), exp_ill);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("ill after flush", 8'(illegal), exp_ill);
    in_valid = 1'b1; alu_op = 2'b00;
    step();
    in_valid = 1'b0;
    chk("ill sticky", 8'(illegal), exp_ill);
    chk("ill next alu_ctrl", 8'(alu_ctrl), 8'h8);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_md_run();
    test_flush();
    test_async_reset();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
